time_set_ctrl: RTL and testbench

- Set-mode controller for the calendar counter (seconds/minutes/hours/days/months).
- Gates the one-second tick into the counter while the user edits. Keeps a shadow copy of all fields, stepped by button pulses.
- Commits the shadow copy to the counter over a valid/ready load handshake.
- Sits between the one-second pulse generator, the debounced button front-end and the counter datapath.

---
 rtl/time_set_pkg.sv | 24 ++
 rtl/time_set_ctrl_field_stepper.sv | 16 +
 rtl/time_set_ctrl.sv | 90 +++++++++
 tb/tb_time_set_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// time_set_pkg: shared state encoding, field select codes and default field limits
package time_set_pkg;
   localparam logic [2:0] FS_NONE = 3'd0;
   localparam logic [2:0] FS_MON  = 3'd1;
   localparam logic [2:0] FS_DAY  = 3'd2;
   localparam logic [2:0] FS_HR   = 3'd3;
   localparam logic [2:0] FS_MIN  = 3'd4;
   localparam logic [2:0] FS_SEC  = 3'd5;
   // Edit states share their field_sel code so the selector is the state itself
   typedef enum logic [2:0] {
      RUN   = FS_NONE,
      E_MON = FS_MON,
      E_DAY = FS_DAY,
      E_HR  = FS_HR,
      E_MIN = FS_MIN,
      E_SEC = FS_SEC,
      LOAD  = 3'd6
   } state_e;
   localparam int SEC_MAX_D = 59;
   localparam int MIN_MAX_D = 59;
   localparam int HR_MAX_D  = 23;
   localparam int DAY_MAX_D = 29;
   localparam int MON_MAX_D = 11;
endpackage

// File: rtl/time_set_ctrl_field_stepper.sv
// field_stepper: one-step wrapping increment/decrement of a calendar field
module field_stepper #(
   parameter int W   = 6,
   parameter int MAX = 59
) (
   input  logic [W-1:0] value,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] next_value
);
   localparam logic [W-1:0] TOP = W'(MAX);
   // Values captured above TOP wrap to 0 on inc and simply step down on dec
   assign next_value = (inc && !dec) ? ((value >= TOP) ? '0 : value + 1'b1)
                     : (dec && !inc) ? ((value == '0) ? TOP : value - 1'b1)
                     : value;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: calendar set-mode controller with shadow edit and load handshake; TIME_SET_TIMEOUT_EN adds idle abort
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int SEC_MAX = SEC_MAX_D,
  parameter int MIN_MAX = MIN_MAX_D,
  parameter int HR_MAX  = HR_MAX_D,
  parameter int DAY_MAX = DAY_MAX_D,
  parameter int MON_MAX = MON_MAX_D,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [5:0] cur_sec,
  input  logic [5:0] cur_min,
  input  logic [4:0] cur_hr,
  input  logic [4:0] cur_day,
  input  logic [3:0] cur_mon,
  output logic       tick_out,
  output logic       load_valid,
  input  logic       load_ready,
  output logic [5:0] load_sec,
  output logic [5:0] load_min,
  output logic [4:0] load_hr,
  output logic [4:0] load_day,
  output logic [3:0] load_mon,
  output logic       set_active,
  output logic [2:0] field_sel,
  output logic       blink
);
  state_e     state, state_nx;
  logic [5:0] sh_sec, sh_min, nx_sec, nx_min;
  logic [4:0] sh_hr, sh_day, nx_hr, nx_day;
  logic [3:0] sh_mon, nx_mon;
  logic       edit, edit_nx, timeout;
  assign edit       = (state != RUN) && (state != LOAD);
  assign edit_nx    = (state_nx != RUN) && (state_nx != LOAD);
  assign tick_out   = (state == RUN) && tick_in;
  assign load_valid = (state == LOAD);
  assign set_active = (state != RUN);
  assign field_sel  = edit ? state : FS_NONE;
  assign {load_mon, load_day, load_hr, load_min, load_sec} = {sh_mon, sh_day, sh_hr, sh_min, sh_sec};
  field_stepper #(.W(4), .MAX(MON_MAX)) u_mon (.value(sh_mon), .inc(btn_inc && state == E_MON),
    .dec(btn_dec && state == E_MON), .next_value(nx_mon));
  field_stepper #(.W(5), .MAX(DAY_MAX)) u_day (.value(sh_day), .inc(btn_inc && state == E_DAY),
    .dec(btn_dec && state == E_DAY), .next_value(nx_day));
  field_stepper #(.W(5), .MAX(HR_MAX)) u_hr (.value(sh_hr), .inc(btn_inc && state == E_HR),
    .dec(btn_dec && state == E_HR), .next_value(nx_hr));
  field_stepper #(.W(6), .MAX(MIN_MAX)) u_min (.value(sh_min), .inc(btn_inc && state == E_MIN),
    .dec(btn_dec && state == E_MIN), .next_value(nx_min));
  field_stepper #(.W(6), .MAX(SEC_MAX)) u_sec (.value(sh_sec), .inc(btn_inc && state == E_SEC),
    .dec(btn_dec && state == E_SEC), .next_value(nx_sec));
`ifdef TIME_SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] idle;
  logic          any_btn;
  assign any_btn = btn_mode || btn_inc || btn_dec;
  assign timeout = edit && tick_in && !any_btn && (idle == TW'(TIMEOUT_TICKS - 1));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) idle <= '0;
    else idle <= (!edit || any_btn || timeout) ? '0 : idle + TW'(tick_in);
`else
  assign timeout = 1'b0;
`endif
  always_comb
    state_nx = (state == RUN)  ? (btn_mode ? E_MON : RUN)
             : (state == LOAD) ? (load_ready ? RUN : LOAD)
             : timeout         ? RUN
             : btn_mode        ? ((state == E_SEC) ? LOAD : state_e'(state + 3'd1))
             : state;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= RUN;
      blink <= 1'b0;
      {sh_mon, sh_day, sh_hr, sh_min, sh_sec} <= '0;
    end else begin
      state <= state_nx;
      blink <= edit && edit_nx && (blink ^ tick_in);
      if (state == RUN && btn_mode)
        {sh_mon, sh_day, sh_hr, sh_min, sh_sec} <= {cur_mon, cur_day, cur_hr, cur_min, cur_sec};
      else if (timeout)
        {sh_mon, sh_day, sh_hr, sh_min, sh_sec} <= '0;
      else if (edit)
        {sh_mon, sh_day, sh_hr, sh_min, sh_sec} <= {nx_mon, nx_day, nx_hr, nx_min, nx_sec};
    end
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;
  logic       clk = 1'b0;
  logic       reset_n, tick_in, btn_mode, btn_inc, btn_dec, load_ready;
  logic [5:0] cur_sec, cur_min, load_sec, load_min;
  logic [4:0] cur_hr, cur_day, load_hr, load_day;
  logic [3:0] cur_mon, load_mon;
  logic       tick_out, load_valid, set_active, blink;
  logic [2:0] field_sel;
  int         errors = 0;
  int         checks = 0;
  logic       lv_seen;
  always #5 clk = ~clk;
  time_set_ctrl #(.TIMEOUT_TICKS(3)) dut (
    .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .btn_mode(btn_mode),
    .btn_inc(btn_inc), .btn_dec(btn_dec), .cur_sec(cur_sec), .cur_min(cur_min),
    .cur_hr(cur_hr), .cur_day(cur_day), .cur_mon(cur_mon), .tick_out(tick_out),
    .load_valid(load_valid), .load_ready(load_ready), .load_sec(load_sec),
    .load_min(load_min), .load_hr(load_hr), .load_day(load_day), .load_mon(load_mon),
    .set_active(set_active), .field_sel(field_sel), .blink(blink)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input logic m, input logic i, input logic d, input logic t);
    btn_mode = m; btn_inc = i; btn_dec = d; tick_in = t;
    @(posedge clk); #1;
    btn_mode = 0; btn_inc = 0; btn_dec = 0; tick_in = 0;
  endtask
  function automatic logic [25:0] shadow();
    return {load_mon, load_day, load_hr, load_min, load_sec};
  endfunction
  initial begin
    reset_n = 0; tick_in = 0; btn_mode = 0; btn_inc = 0; btn_dec = 0; load_ready = 0;
    cur_mon = 4'd3; cur_day = 5'd5; cur_hr = 5'd10; cur_min = 6'd20; cur_sec = 6'd30;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_set_active", set_active, 0);
    chk("rst_field_sel", field_sel, 0);
    chk("rst_load_valid", load_valid, 0);
    chk("rst_blink", blink, 0);
    chk("rst_shadow", shadow(), 0);
    reset_n = 1;
    for (int k = 0; k < 3; k++) begin
      repeat (9) step(0, 0, 0, 0);
      tick_in = 1; #1;
      chk("run_tick_out_hi", tick_out, 1);
      chk("run_set_active", set_active, 0);
      @(posedge clk); #1; tick_in = 0; #1;
      chk("run_tick_out_lo", tick_out, 0);
    end
    step(0, 1, 1, 0);
    chk("run_btn_ignored", shadow(), 0);
    step(1, 0, 0, 0);
    chk("emon_field_sel", field_sel, 1);
    chk("emon_set_active", set_active, 1);
    chk("emon_capture", shadow(), {4'd3, 5'd5, 5'd10, 6'd20, 6'd30});
    chk("emon_blink", blink, 0);
    repeat (8) step(0, 1, 0, 0);
    chk("mon_inc_11", load_mon, 11);
    step(0, 1, 0, 0);
    chk("mon_wrap_0", load_mon, 0);
    step(1, 0, 0, 0);
    chk("eday_field_sel", field_sel, 2);
    step(1, 0, 0, 0);
    chk("ehr_field_sel", field_sel, 3);
    repeat (10) step(0, 0, 1, 0);
    chk("hr_dec_0", load_hr, 0);
    step(0, 0, 1, 0);
    chk("hr_wrap_23", load_hr, 23);
    step(0, 1, 1, 0);
    chk("hr_inc_dec_hold", load_hr, 23);
    tick_in = 1; #1;
    chk("edit_tick_gated", tick_out, 0);
    @(posedge clk); #1; tick_in = 0;
    chk("blink_toggle_1", blink, 1);
    step(0, 0, 0, 1);
    chk("blink_toggle_0", blink, 0);
    step(1, 1, 0, 0);
    chk("mode_inc_hr_wrap", load_hr, 0);
    chk("emin_field_sel", field_sel, 4);
    step(0, 0, 1, 0);
    chk("min_dec", load_min, 19);
    step(1, 0, 0, 0);
    chk("esec_field_sel", field_sel, 5);
    step(0, 1, 0, 0);
    chk("sec_inc", load_sec, 31);
    step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      chk("load_valid_hold", load_valid, 1);
      chk("load_data_hold", shadow(), {4'd0, 5'd5, 5'd0, 6'd19, 6'd31});
      chk("load_field_sel", field_sel, 0);
      chk("load_tick_gated", tick_out, 0);
      step(k == 1, k == 2, k == 3, 1);
    end
    chk("load_blink", blink, 0);
    chk("load_set_active", set_active, 1);
    load_ready = 1;
    step(0, 0, 0, 0);
    chk("load_done_valid", load_valid, 0);
    chk("load_done_active", set_active, 0);
    step(0, 0, 0, 0);
    chk("ready_in_run_ignored", set_active, 0);
    load_ready = 0;
    repeat (6) step(1, 0, 0, 0);
    chk("load2_valid", load_valid, 1);
    #2 reset_n = 0; #1;
    chk("arst_load_valid", load_valid, 0);
    chk("arst_set_active", set_active, 0);
    chk("arst_shadow", shadow(), 0);
    @(posedge clk); #1; reset_n = 1;
    repeat (4) step(1, 0, 0, 0);
    chk("idle_emin", field_sel, 4);
    lv_seen = 0;
`ifdef TIME_SET_TIMEOUT_EN
    step(0, 0, 0, 1); step(0, 0, 0, 0); step(0, 0, 0, 1);
    chk("to_not_yet", field_sel, 4);
    step(0, 0, 0, 0); step(0, 0, 0, 1);
    chk("to_run_active", set_active, 0);
    chk("to_blink", blink, 0);
    repeat (3) begin
      if (load_valid) lv_seen = 1;
      step(0, 0, 0, 0);
    end
`else
    for (int k = 0; k < 50; k++) begin
      step(0, 0, 0, 1);
      if (load_valid) lv_seen = 1;
      step(0, 0, 0, 0);
    end
    chk("no_to_emin", field_sel, 4);
    chk("no_to_active", set_active, 1);
`endif
    chk("idle_no_load", lv_seen, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
